gpr_scoreboard: RTL

//  Parametrised general-purpose register file with two combinational read ports,
//  one write-back port, write-to-read bypass and a per-register pending-write

---
 rtl/gpr_scoreboard.sv | 101 ++++++++++
 1 files changed

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: ID-stage register file with a pending-write scoreboard.
//  Two combinational read ports with optional write-to-read bypass, one
//  write-back port, and a saturating per-register count of issued but not yet
//  written-back destinations that drives operand hazards and issue back-pressure.
// Ports:
//  clk, rst               clock, synchronous active-high reset
//  rs1, rs2               read selects
//  rData1, rData2         read data (combinational)
//  we, ws, wData          write-back enable / select / data
//  iss_valid, iss_rd      destination issue request
//  iss_ready              issue accepted when iss_valid && iss_ready (comb)
//  hazard1, hazard2       operand still waiting on an outstanding write (comb)
//  pend_any               any register has an outstanding write (comb)
//  err_unf                sticky: write-back to a register with nothing pending
module gpr_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rData1,
  output logic [DATA_W-1:0] rData2,
  input  logic              we,
  input  logic [ADDR_W-1:0] ws,
  input  logic [DATA_W-1:0] wData,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  output logic              hazard1,
  output logic              hazard2,
  output logic              pend_any,
  output logic              err_unf
);

  localparam int unsigned    NREG    = 1 << ADDR_W;
  localparam bit             ZR      = (ZERO_REG != 0);
  localparam bit             BP      = (BYPASS != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];

  logic rs1_zero, rs2_zero, ws_zero, rd_zero;
  logic fwd1, fwd2;
  logic issue_acc, wb_cnt, same_reg;

  // Register 0 is hardwired only when ZERO_REG is set
  assign rs1_zero = ZR && (rs1 == ADDR_W'(0));
  assign rs2_zero = ZR && (rs2 == ADDR_W'(0));
  assign ws_zero  = ZR && (ws == ADDR_W'(0));
  assign rd_zero  = ZR && (iss_rd == ADDR_W'(0));

  // Read ports with same-cycle write forwarding
  assign fwd1   = BP && we && (ws == rs1) && !rs1_zero;
  assign fwd2   = BP && we && (ws == rs2) && !rs2_zero;
  assign rData1 = rs1_zero ? '0 : (fwd1 ? wData : regs[rs1]);
  assign rData2 = rs2_zero ? '0 : (fwd2 ? wData : regs[rs2]);

  // A saturated destination can still issue if its write-back frees a slot now
  assign iss_ready = !iss_valid || (cnt[iss_rd] != CNT_MAX) ||
                     (we && (ws == iss_rd)) || rd_zero;

  // Last outstanding write arriving this cycle is forwarded, so no stall
  assign hazard1 = !rs1_zero && (cnt[rs1] != '0) && !(fwd1 && (cnt[rs1] == CNT_ONE));
  assign hazard2 = !rs2_zero && (cnt[rs2] != '0) && !(fwd2 && (cnt[rs2] == CNT_ONE));

  // OR of all pending counters
  always_comb begin
    pend_any = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt[r] != '0) pend_any = 1'b1;
    end
  end

  assign issue_acc = iss_valid && iss_ready && !rd_zero;
  assign wb_cnt    = we && !ws_zero;
  assign same_reg  = issue_acc && wb_cnt && (ws == iss_rd);

  // Register file, counters and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_unf <= 1'b0;
    end else begin
      if (we && !ws_zero) regs[ws] <= wData;
      if (issue_acc && !same_reg) cnt[iss_rd] <= cnt[iss_rd] + CNT_ONE;
      if (wb_cnt && !same_reg && (cnt[ws] != '0)) cnt[ws] <= cnt[ws] - CNT_ONE;
      if (wb_cnt && (cnt[ws] == '0)) err_unf <= 1'b1;
    end
  end

endmodule
